// File: rtl/spi_slave_ram_ctrl.sv
// SPI slave front-end for the single-port RAM: deserialises 10-bit command
// words onto rx_data/rx_valid and serialises RAM read data back onto MISO.
module spi_slave_ram_ctrl #(
    parameter int TX_WAIT_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    typedef enum logic [1:0] {PH_SHIFT, PH_WAIT, PH_OUT, PH_HOLD} phase_t;

    localparam logic [3:0] WAIT_MAX = 4'(TX_WAIT_MAX);

    state_t     state_r, state_s;
    phase_t     phase_r, phase_s;
    logic [8:0] shift_r, shift_s;
    logic [3:0] bit_cnt_r, bit_cnt_s;
    logic [3:0] wait_cnt_r, wait_cnt_s;
    logic [7:0] tx_shift_r, tx_shift_s;
    logic       rd_addr_seen_r, rd_addr_seen_s;
    logic       miso_r, miso_s;
    logic [9:0] rx_data_r, rx_data_s;
    logic       rx_valid_r, rx_valid_s;

    assign MISO     = miso_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            phase_r        <= PH_SHIFT;
            shift_r        <= 9'd0;
            bit_cnt_r      <= 4'd0;
            wait_cnt_r     <= 4'd0;
            tx_shift_r     <= 8'd0;
            rd_addr_seen_r <= 1'b0;
            miso_r         <= 1'b0;
            rx_data_r      <= 10'd0;
            rx_valid_r     <= 1'b0;
        end else begin
            state_r        <= state_s;
            phase_r        <= phase_s;
            shift_r        <= shift_s;
            bit_cnt_r      <= bit_cnt_s;
            wait_cnt_r     <= wait_cnt_s;
            tx_shift_r     <= tx_shift_s;
            rd_addr_seen_r <= rd_addr_seen_s;
            miso_r         <= miso_s;
            rx_data_r      <= rx_data_s;
            rx_valid_r     <= rx_valid_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s        = state_r;
        phase_s        = phase_r;
        shift_s        = shift_r;
        bit_cnt_s      = bit_cnt_r;
        wait_cnt_s     = wait_cnt_r;
        tx_shift_s     = tx_shift_r;
        rd_addr_seen_s = rd_addr_seen_r;
        miso_s         = 1'b0;
        rx_data_s      = rx_data_r;
        rx_valid_s     = 1'b0;

        case (state_r)
            IDLE: begin
                phase_s    = PH_SHIFT;
                bit_cnt_s  = 4'd0;
                wait_cnt_s = 4'd0;
                if (!SS_n) begin
                    state_s = CHK_CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_s = IDLE;
                end else begin
                    shift_s   = {8'd0, MOSI};
                    bit_cnt_s = 4'd0;
                    phase_s   = PH_SHIFT;
                    if (!MOSI) begin
                        state_s = WRITE;
                    end else if (!rd_addr_seen_r) begin
                        state_s = READ_ADD;
                    end else begin
                        state_s = READ_DATA;
                    end
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    // Deselect discards any partial word and clears the counters.
                    state_s    = IDLE;
                    phase_s    = PH_SHIFT;
                    bit_cnt_s  = 4'd0;
                    wait_cnt_s = 4'd0;
                end else begin
                    case (phase_r)
                        PH_SHIFT: begin
                            shift_s   = {shift_r[7:0], MOSI};
                            bit_cnt_s = bit_cnt_r + 4'd1;
                            if (bit_cnt_r == 4'd8) begin
                                rx_data_s  = {shift_r, MOSI};
                                rx_valid_s = 1'b1;
                                bit_cnt_s  = 4'd0;
                                wait_cnt_s = 4'd0;
                                if (state_r == READ_DATA) begin
                                    phase_s        = PH_WAIT;
                                    rd_addr_seen_s = 1'b0;
                                end else if (state_r == READ_ADD) begin
                                    phase_s        = PH_HOLD;
                                    rd_addr_seen_s = 1'b1;
                                end else begin
                                    phase_s = PH_HOLD;
                                end
                            end else begin
                                phase_s = PH_SHIFT;
                            end
                        end
                        PH_WAIT: begin
                            if (tx_valid) begin
                                tx_shift_s = tx_data;
                                bit_cnt_s  = 4'd8;
                                phase_s    = PH_OUT;
                            end else begin
                                wait_cnt_s = wait_cnt_r + 4'd1;
                                if ((wait_cnt_r + 4'd1) == WAIT_MAX) begin
                                    phase_s = PH_HOLD;
                                end else begin
                                    phase_s = PH_WAIT;
                                end
                            end
                        end
                        PH_OUT: begin
                            miso_s     = tx_shift_r[7];
                            tx_shift_s = {tx_shift_r[6:0], 1'b0};
                            bit_cnt_s  = bit_cnt_r - 4'd1;
                            if (bit_cnt_r == 4'd1) begin
                                phase_s = PH_HOLD;
                            end else begin
                                phase_s = PH_OUT;
                            end
                        end
                        PH_HOLD: begin
                            phase_s = PH_HOLD;
                        end
                        default: begin
                            phase_s = PH_HOLD;
                        end
                    endcase
                end
            end
            default: begin
                state_s = IDLE;
                phase_s = PH_SHIFT;
            end
        endcase
    end

endmodule
